i2c_target: RTL and testbench

Byte-oriented I2C target (slave) that answers the I2C master controlled by the UART debug command path. It fronts an 8-bit addressed register space through a simple strobe interface. It runs entirely in the system clock domain, oversampling SCL/SDA, and drives SDA open-drain via an output-enable. It is the responder used on the board's slave I2C pins and as the loopback target for master-side bring-up.

---
 rtl/i2c_target.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_target.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// i2c_target
// Byte-oriented I2C target answering a single 7-bit device address. It fronts
// an 8-bit addressed register space through write/read strobes. SCL and SDA
// are oversampled in the sysclk domain; SDA is driven open-drain via sda_oe.
//
// Ports:
//   sysclk     system clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   scl_i      raw SCL pin level
//   sda_i      raw SDA pin level
//   sda_oe     1 = pull SDA low, 0 = release
//   reg_addr   register pointer presented to the register space
//   reg_wdata  byte received from the master
//   reg_we     one-cycle write strobe (reg_addr/reg_wdata valid)
//   reg_re     one-cycle read strobe (reg_rdata sampled)
//   reg_rdata  read data for reg_addr
//   busy       high from an address-matched START until STOP
//   stop_evt   one-cycle pulse on every STOP condition
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       stop_evt
);

  typedef enum logic [3:0] {
    IDLE, DEV, DACK, PTR, PACK, WDAT, WACK, RDAT, RACK, IGNORE
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [7:0] shift;
  logic [3:0] cnt;
  logic       rw;
  logic       ack_on;
  logic       load_pend;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // Two-flop synchronizers plus one history flop per line. They reset to the
  // idle (high) bus level so that reset release does not fake a START/STOP.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  // START/STOP require SCL high on both the current and previous sample so
  // an SDA change right at an SCL edge is never mistaken for a condition.
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & ~sda_s2 & sda_d;
  assign stop_det  = scl_s2 & scl_d & sda_s2 & ~sda_d;
  assign rx_byte   = {shift[6:0], sda_s2};

  // Protocol FSM. ACK phases assert sda_oe on the first SCL fall and release
  // on the second. Read data is driven at each SCL fall; the byte after a
  // master ACK is fetched one cycle after the rising edge (load_pend), when
  // reg_re and the incremented reg_addr are visible to the register space.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      stop_evt  <= 1'b0;
      shift     <= 8'h00;
      cnt       <= 4'd0;
      rw        <= 1'b0;
      ack_on    <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      reg_we   <= 1'b0;
      reg_re   <= 1'b0;
      stop_evt <= 1'b0;
      if (reg_we) reg_addr <= reg_addr + 8'd1;
      if (load_pend) begin
        shift     <= reg_rdata;
        load_pend <= 1'b0;
      end
      if (stop_det) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        ack_on    <= 1'b0;
        load_pend <= 1'b0;
        busy      <= 1'b0;
        stop_evt  <= 1'b1;
        cnt       <= 4'd0;
      end else if (start_det) begin
        state     <= DEV;
        sda_oe    <= 1'b0;
        ack_on    <= 1'b0;
        load_pend <= 1'b0;
        cnt       <= 4'd0;
      end else begin
        case (state)
          IDLE: ;
          DEV, PTR, WDAT: begin
            if (scl_rise) begin
              shift <= rx_byte;
              cnt   <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                cnt <= 4'd0;
                if (state == DEV) begin
                  // General call (address 0) is deliberately not answered.
                  if (rx_byte[7:1] == DEV_ADDR && rx_byte[7:1] != 7'd0) begin
                    rw    <= rx_byte[0];
                    busy  <= 1'b1;
                    state <= DACK;
                  end else begin
                    busy  <= 1'b0;
                    state <= IGNORE;
                  end
                end else if (state == PTR) begin
                  reg_addr <= rx_byte;
                  state    <= PACK;
                end else begin
                  reg_wdata <= rx_byte;
                  reg_we    <= 1'b1;
                  state     <= WACK;
                end
              end
            end
          end
          DACK, PACK, WACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
                if (state == DACK && rw) begin
                  // First read byte: MSB goes out on this same fall.
                  reg_re <= 1'b1;
                  sda_oe <= ~reg_rdata[7];
                  shift  <= {reg_rdata[6:0], 1'b0};
                  cnt    <= 4'd1;
                  state  <= RDAT;
                end else if (state == DACK) begin
                  state <= PTR;
                end else begin
                  state <= WDAT;
                end
              end
            end
          end
          RDAT: begin
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                sda_oe <= 1'b0;
                cnt    <= 4'd0;
                state  <= RACK;
              end else begin
                sda_oe <= ~shift[7];
                shift  <= {shift[6:0], 1'b0};
                cnt    <= cnt + 4'd1;
              end
            end
          end
          RACK: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                reg_addr  <= reg_addr + 8'd1;
                reg_re    <= 1'b1;
                load_pend <= 1'b1;
                cnt       <= 4'd0;
                state     <= RDAT;
              end else begin
                state <= IGNORE;
              end
            end
          end
          IGNORE: sda_oe <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target
// Bit-banged I2C master driving i2c_target, with a small register space and
// a reference model of the expected register contents and strobe sequence.
module tb_i2c_target;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       msda = 1'b1;
  wire        sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy, stop_evt;

  // Open-drain bus: low if either side pulls
  assign sda_line = msda & ~sda_oe;

  i2c_target dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .stop_evt  (stop_evt)
  );

  always #5 sysclk = ~sysclk;

  int        vectors = 0;
  int        miscompares = 0;
  int        ph = 10;
  bit        fill_xor = 1'b0;
  bit [7:0]  mem [256];
  bit [7:0]  model_mem [256];
  logic [15:0] we_q [$];
  logic [7:0]  re_q [$];
  int        stop_cnt = 0, busy_cycles = 0, oe_cycles = 0, both_cnt = 0, glitch_cnt = 0;
  logic      prev_scl = 1'b1, prev_oe = 1'b0;

  assign reg_rdata = fill_xor ? (reg_addr ^ 8'hFF) : mem[reg_addr];

  // Register space and bus observers, sampled on the falling sysclk edge
  always @(negedge sysclk) begin
    if (reg_we) begin
      we_q.push_back({reg_addr, reg_wdata});
      mem[reg_addr] <= reg_wdata;
    end
    if (reg_re) re_q.push_back(reg_addr);
    if (reg_we && reg_re) both_cnt <= both_cnt + 1;
    if (stop_evt) stop_cnt <= stop_cnt + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
    if (sda_oe) oe_cycles <= oe_cycles + 1;
    if (!rst && scl && prev_scl && (sda_oe !== prev_oe)) glitch_cnt <= glitch_cnt + 1;
    prev_scl <= scl;
    prev_oe  <= sda_oe;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clks(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // One SCL clock: SDA set mid-low, then SCL high for ph cycles while sampling
  task automatic clock_bit(input bit b, output bit rd, output bit all_low);
    clks(ph / 2);
    msda = b;
    clks(ph - ph / 2);
    scl = 1'b1;
    all_low = 1'b1;
    rd = 1'b1;
    for (int i = 0; i < ph; i++) begin
      clks(1);
      if (sda_line) all_low = 1'b0;
      if (i == ph / 2) rd = sda_line;
    end
    scl = 1'b0;
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      clks(ph / 2);
      msda = 1'b1;
      clks(ph - ph / 2);
      scl = 1'b1;
    end
    clks(ph);
    msda = 1'b0;
    clks(ph);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    clks(ph / 2);
    msda = 1'b0;
    clks(ph - ph / 2);
    scl = 1'b1;
    clks(ph);
    msda = 1'b1;
    clks(ph);
  endtask

  task automatic send_byte(input logic [7:0] d, output bit ack, output bit stable);
    bit rd, al;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], rd, al);
    clock_bit(1'b1, rd, al);
    ack = ~rd;
    stable = al;
  endtask

  task automatic recv_byte(input bit give_ack, output logic [7:0] d);
    bit rd, al;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, rd, al);
      d[i] = rd;
    end
    clock_bit(~give_ack, rd, al);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clks(3);
    vectors++;
    if ({sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, stop_evt} !== 21'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %0h expected 0",
               {sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, stop_evt});
    end
    rst = 1'b0;
    clks(4);
  endtask

  task automatic test_write();
    bit ack [4];
    bit st;
    logic [7:0] bytes [4];
    logic [15:0] exp_we [2];
    int s0, b0;
    bytes = '{8'hA0, 8'h10, 8'h5A, 8'hC3};
    exp_we = '{16'h105A, 16'h11C3};
    we_q.delete();
    s0 = stop_cnt;
    b0 = busy_cycles;
    bus_start();
    for (int i = 0; i < 4; i++) send_byte(bytes[i], ack[i], st);
    bus_stop();
    clks(4);
    model_mem[8'h10] = 8'h5A;
    model_mem[8'h11] = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ack[i] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL write_ack%0d: got %0d expected 1", i, ack[i]);
      end
    end
    vectors++;
    if (we_q.size() !== 2) begin
      miscompares++;
      $display("[TB] FAIL write_we_count: got %0d expected 2", we_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (we_q[i] !== exp_we[i]) begin
          miscompares++;
          $display("[TB] FAIL write_we%0d: got %h expected %h", i, we_q[i], exp_we[i]);
        end
      end
    end
    vectors++;
    if (stop_cnt - s0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL write_stop_evt: got %0d expected 1", stop_cnt - s0);
    end
    vectors++;
    if (busy !== 1'b0 || busy_cycles == b0) begin
      miscompares++;
      $display("[TB] FAIL write_busy: got busy=%0d cycles=%0d expected 0 after, >0 during",
               busy, busy_cycles - b0);
    end
  endtask

  task automatic test_read_wrap();
    bit ack [3];
    bit st;
    logic [7:0] d [3];
    logic [7:0] a;
    fill_xor = 1'b1;
    re_q.delete();
    bus_start();
    send_byte(8'hA0, ack[0], st);
    send_byte(8'hFE, ack[1], st);
    bus_start();
    send_byte(8'hA1, ack[2], st);
    recv_byte(1'b1, d[0]);
    recv_byte(1'b1, d[1]);
    recv_byte(1'b0, d[2]);
    bus_stop();
    clks(4);
    fill_xor = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (ack[i] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL read_ack%0d: got %0d expected 1", i, ack[i]);
      end
    end
    vectors++;
    if (re_q.size() !== 3) begin
      miscompares++;
      $display("[TB] FAIL read_re_count: got %0d expected 3", re_q.size());
    end
    for (int k = 0; k < 3; k++) begin
      a = 8'hFE + 8'(k);
      vectors++;
      if (d[k] !== (a ^ 8'hFF)) begin
        miscompares++;
        $display("[TB] FAIL read_data%0d: got %h expected %h", k, d[k], a ^ 8'hFF);
      end
      if (k < re_q.size()) begin
        vectors++;
        if (re_q[k] !== a) begin
          miscompares++;
          $display("[TB] FAIL read_re_addr%0d: got %h expected %h", k, re_q[k], a);
        end
      end
    end
  endtask

  task automatic test_mismatch();
    bit ack [3];
    bit st;
    int oe0, b0;
    we_q.delete();
    re_q.delete();
    oe0 = oe_cycles;
    b0 = busy_cycles;
    bus_start();
    send_byte(8'hA2, ack[0], st);
    send_byte(8'h33, ack[1], st);
    bus_stop();
    bus_start();
    send_byte(8'h00, ack[2], st);
    bus_stop();
    clks(4);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (ack[i] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mismatch_nack%0d: got ack=%0d expected 0", i, ack[i]);
      end
    end
    vectors++;
    if (oe_cycles != oe0 || busy_cycles != b0 || we_q.size() != 0 || re_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL mismatch_quiet: got oe=%0d busy=%0d we=%0d re=%0d expected all 0",
               oe_cycles - oe0, busy_cycles - b0, we_q.size(), re_q.size());
    end
  endtask

  task automatic test_stop_mid_byte();
    bit ack, st, rd, al;
    logic [7:0] p, p2, dv;
    p  = 8'($urandom_range(0, 255));
    p2 = 8'($urandom_range(0, 255));
    dv = 8'($urandom_range(0, 255));
    we_q.delete();
    bus_start();
    send_byte(8'hA0, ack, st);
    send_byte(p, ack, st);
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom_range(0, 1)), rd, al);
    bus_stop();
    clks(4);
    vectors++;
    if (we_q.size() !== 0 || sda_oe !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stop_mid_byte: got we=%0d oe=%0d busy=%0d expected 0 0 0",
               we_q.size(), sda_oe, busy);
    end
    bus_start();
    send_byte(8'hA0, ack, st);
    send_byte(p2, ack, st);
    send_byte(dv, ack, st);
    bus_stop();
    clks(4);
    model_mem[p2] = dv;
    vectors++;
    if (we_q.size() !== 1 || we_q[0] !== {p2, dv} || ack !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stop_recover: got n=%0d ack=%0d expected one write %h", we_q.size(), ack, {p2, dv});
    end
  endtask

  task automatic test_reset_mid_read();
    bit ack [3];
    bit st;
    logic [7:0] p, dv;
    p  = 8'($urandom_range(0, 255));
    dv = 8'($urandom_range(0, 255));
    fill_xor = 1'b1;
    bus_start();
    send_byte(8'hA0, ack[0], st);
    send_byte(8'h80, ack[1], st);
    bus_start();
    send_byte(8'hA1, ack[2], st);
    clks(6);
    // 0x80 ^ 0xFF = 0x7F: MSB is 0, so the target is pulling SDA low now
    vectors++;
    if (sda_oe !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_read_driving: got %0d expected 1", sda_oe);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, stop_evt} !== 21'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_async_outputs: got %0h expected 0",
               {sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, stop_evt});
    end
    clks(3);
    rst = 1'b0;
    fill_xor = 1'b0;
    msda = 1'b1;
    clks(ph);
    scl = 1'b1;
    clks(ph);
    we_q.delete();
    bus_start();
    send_byte(8'hA0, ack[0], st);
    send_byte(p, ack[1], st);
    send_byte(dv, ack[2], st);
    bus_stop();
    clks(4);
    model_mem[p] = dv;
    vectors++;
    if ({ack[0], ack[1], ack[2]} !== 3'b111 || we_q.size() !== 1 || we_q[0] !== {p, dv}) begin
      miscompares++;
      $display("[TB] FAIL rst_recover_write: got acks=%b n=%0d expected 111 and write %h",
               {ack[0], ack[1], ack[2]}, we_q.size(), {p, dv});
    end
  endtask

  task automatic test_random();
    bit ack, st;
    int n, acks;
    logic [7:0] p, dv, got;
    for (int it = 0; it < 4; it++) begin
      ph = $urandom_range(8, 12);
      p  = 8'($urandom_range(0, 255));
      n  = $urandom_range(1, 4);
      we_q.delete();
      acks = 0;
      bus_start();
      send_byte(8'hA0, ack, st); acks += int'(ack);
      send_byte(p, ack, st);     acks += int'(ack);
      for (int i = 0; i < n; i++) begin
        dv = 8'($urandom_range(0, 255));
        model_mem[p + 8'(i)] = dv;
        send_byte(dv, ack, st);
        acks += int'(ack);
      end
      bus_stop();
      clks(4);
      vectors++;
      if (acks != n + 2 || we_q.size() != n) begin
        miscompares++;
        $display("[TB] FAIL rand%0d_write: got acks=%0d writes=%0d expected %0d %0d",
                 it, acks, we_q.size(), n + 2, n);
      end
      for (int i = 0; i < n && i < we_q.size(); i++) begin
        vectors++;
        if (we_q[i] !== {p + 8'(i), model_mem[p + 8'(i)]}) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_we%0d: got %h expected %h", it, i, we_q[i],
                   {p + 8'(i), model_mem[p + 8'(i)]});
        end
      end
      bus_start();
      send_byte(8'hA0, ack, st);
      send_byte(p, ack, st);
      bus_start();
      send_byte(8'hA1, ack, st);
      for (int i = 0; i < n; i++) begin
        recv_byte(i != n - 1, got);
        vectors++;
        if (got !== model_mem[p + 8'(i)]) begin
          miscompares++;
          $display("[TB] FAIL rand%0d_rd%0d: got %h expected %h", it, i, got, model_mem[p + 8'(i)]);
        end
      end
      bus_stop();
      clks(4);
    end
    ph = 10;
  endtask

  task automatic test_glitch_free();
    bit ack, st;
    int stable_acks;
    logic [7:0] got;
    ph = 8;
    stable_acks = 0;
    bus_start();
    send_byte(8'hA0, ack, st); stable_acks += int'(ack && st);
    send_byte(8'h42, ack, st); stable_acks += int'(ack && st);
    send_byte(8'h99, ack, st); stable_acks += int'(ack && st);
    model_mem[8'h43] = model_mem[8'h43];
    bus_start();
    send_byte(8'hA1, ack, st); stable_acks += int'(ack && st);
    recv_byte(1'b0, got);
    bus_stop();
    clks(4);
    ph = 10;
    vectors++;
    if (stable_acks != 4) begin
      miscompares++;
      $display("[TB] FAIL glitch_ack_hold: got %0d stable ACKs expected 4", stable_acks);
    end
    // Pointer advanced past the 0x42 write, so the read returns mem[0x43]
    vectors++;
    if (got !== mem[8'h43]) begin
      miscompares++;
      $display("[TB] FAIL glitch_read: got %h expected %h", got, mem[8'h43]);
    end
    vectors++;
    if (glitch_cnt != 0 || both_cnt != 0) begin
      miscompares++;
      $display("[TB] FAIL glitch_free: got oe-changes-while-SCL-high=%0d we&re=%0d expected 0 0",
               glitch_cnt, both_cnt);
    end
  endtask

  initial begin
    $display("[TB] starting i2c_target bench");
    test_reset();
    test_write();
    test_read_wrap();
    test_mismatch();
    test_stop_mid_byte();
    test_reset_mid_read();
    test_random();
    test_glitch_free();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
